// File: rtl/perf_monitor_unit_pkg.sv
// perf_monitor_unit_pkg: register map, SEL field positions, FSM encodings and NOP encodings for the PMU.
package perf_monitor_unit_pkg;
  localparam logic [5:0] ADDR_CTRL   = 6'h00;
  localparam logic [5:0] ADDR_STATUS = 6'h01;
  localparam logic [5:0] SEL_BASE    = 6'h10;
  localparam logic [5:0] CNT_BASE    = 6'h20;
  localparam int SEL_IDX_MSB    = 4;
  localparam int SEL_W_BIT      = 5;
  localparam int SEL_EN_BIT     = 6;
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_CLEAR_BIT = 1;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [15:0] NOP_C    = 16'h0001;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_FROZEN = 2'd2} pmu_state_e;
  function automatic logic is_nop(input logic [31:0] i);
    return (i == NOP_INST) || (i[15:0] == NOP_C);
  endfunction
endpackage

// File: rtl/perf_monitor_unit_halt_detector.sv
// pmu_halt_detector: flags program end on a run of identical instructions or identical NOPs;
// halt is a one-cycle pulse in the cycle the threshold is reached.
module pmu_halt_detector
  import perf_monitor_unit_pkg::*;
#(
  parameter int IDLE_THRESH = 49,
  parameter int NOP_THRESH  = 8
) (
  input  logic        CLK,
  input  logic        nrst,
  input  logic        en,
  input  logic        rearm,
  input  logic [31:0] inst,
  input  logic        inst_valid,
  output logic        halt
);
  logic [31:0] last_inst_q, last_inst_d;
  logic [15:0] rep_cnt_q, rep_cnt_d, nop_cnt_q, nop_cnt_d;
  logic        upd, same;
  always_comb begin
    upd         = en && inst_valid;
    same        = inst == last_inst_q;
    last_inst_d = rearm ? '0 : (upd && !same) ? inst : last_inst_q;
    rep_cnt_d   = rearm ? '0 : !upd ? rep_cnt_q : same ? rep_cnt_q + 16'd1 : '0;
    nop_cnt_d   = rearm ? '0 : !upd ? nop_cnt_q : !same ? '0 :
                  is_nop(inst) ? nop_cnt_q + 16'd1 : nop_cnt_q;
    halt        = !rearm && upd && same &&
                  (rep_cnt_d == 16'(IDLE_THRESH) || nop_cnt_d == 16'(NOP_THRESH));
  end
  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      last_inst_q <= '0;
      rep_cnt_q   <= '0;
      nop_cnt_q   <= '0;
    end else begin
      last_inst_q <= last_inst_d;
      rep_cnt_q   <= rep_cnt_d;
      nop_cnt_q   <= nop_cnt_d;
    end
  end
endmodule

// File: rtl/perf_monitor_unit.sv
// perf_monitor_unit: event counters with per-counter select/weight, halt-freeze FSM and register port.
// Define PMU_SATURATE_EN to make counters saturate instead of wrapping.
module perf_monitor_unit
  import perf_monitor_unit_pkg::*;
#(
  parameter int NUM_CNT     = 8,
  parameter int CNT_WIDTH   = 32,
  parameter int NUM_EVENTS  = 16,
  parameter int IDLE_THRESH = 49,
  parameter int NOP_THRESH  = 8
) (
  input  logic                  CLK,
  input  logic                  nrst,
  input  logic [NUM_EVENTS-1:0] event_in,
  input  logic [31:0]           inst,
  input  logic                  inst_valid,
  input  logic                  cfg_we,
  input  logic [5:0]            cfg_addr,
  input  logic [CNT_WIDTH-1:0]  cfg_wdata,
  output logic [CNT_WIDTH-1:0]  rd_data,
  output logic                  halt_det,
  output logic                  ovf_any
);
  pmu_state_e             state_q, state_d;
  logic [6:0]             sel_q [NUM_CNT];
  logic [6:0]             sel_d [NUM_CNT];
  logic [CNT_WIDTH-1:0]   cnt_arr [NUM_CNT];
  logic [NUM_CNT-1:0]     ovf_vec;
  logic [CNT_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic [31:0]            ev_ext;
  logic                   start, clr, run, rearm, halt;
  always_comb begin
    ev_ext  = 32'(event_in);
    start   = cfg_we && cfg_addr == ADDR_CTRL && cfg_wdata[CTRL_START_BIT];
    clr     = cfg_we && cfg_addr == ADDR_CTRL && cfg_wdata[CTRL_CLEAR_BIT];
    run     = state_q == ST_RUN;
    rearm   = clr || (start && state_q == ST_FROZEN);
    state_d = clr ? ST_IDLE :
              (start && state_q != ST_RUN) ? ST_RUN :
              (halt && run) ? ST_FROZEN : state_q;
  end
  pmu_halt_detector #(.IDLE_THRESH(IDLE_THRESH), .NOP_THRESH(NOP_THRESH)) u_halt (
    .CLK(CLK), .nrst(nrst), .en(run), .rearm(rearm),
    .inst(inst), .inst_valid(inst_valid), .halt(halt)
  );
  always_comb begin
    for (int i = 0; i < NUM_CNT; i++)
      sel_d[i] = (cfg_we && cfg_addr == 6'(SEL_BASE + i)) ? cfg_wdata[6:0] : sel_q[i];
  end
  for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH:0]   sum;
    logic                 ovf_q, ovf_d, hit, wr;
    always_comb begin
      wr  = cfg_we && cfg_addr == 6'(CNT_BASE + k);
      hit = run && sel_q[k][SEL_EN_BIT] && ev_ext[sel_q[k][SEL_IDX_MSB:0]];
      sum = {1'b0, cnt_q} + {{CNT_WIDTH{1'b0}}, 1'b1} + {{CNT_WIDTH{1'b0}}, sel_q[k][SEL_W_BIT]};
`ifdef PMU_SATURATE_EN
      cnt_d = clr ? '0 : wr ? cfg_wdata : hit ? (sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0]) : cnt_q;
`else
      cnt_d = clr ? '0 : wr ? cfg_wdata : hit ? sum[CNT_WIDTH-1:0] : cnt_q;
`endif
      ovf_d = !clr && (ovf_q || (!wr && hit && sum[CNT_WIDTH]));
    end
    always_ff @(posedge CLK or negedge nrst) begin
      if (!nrst) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
      end
    end
    assign cnt_arr[k] = cnt_q;
    assign ovf_vec[k] = ovf_q;
  end
  // Reads sample pre-write state, so a same-cycle write is not visible until the next read.
  always_comb begin
    rd_data_d = '0;
    if (cfg_addr == ADDR_STATUS) rd_data_d = CNT_WIDTH'({ovf_vec, state_q});
    for (int i = 0; i < NUM_CNT; i++) begin
      if (cfg_addr == 6'(SEL_BASE + i)) rd_data_d = CNT_WIDTH'(sel_q[i]);
      if (cfg_addr == 6'(CNT_BASE + i)) rd_data_d = cnt_arr[i];
    end
  end
  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      state_q   <= ST_IDLE;
      rd_data_q <= '0;
      for (int i = 0; i < NUM_CNT; i++) sel_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      rd_data_q <= rd_data_d;
      for (int i = 0; i < NUM_CNT; i++) sel_q[i] <= sel_d[i];
    end
  end
  assign rd_data  = rd_data_q;
  assign halt_det = state_q == ST_FROZEN;
  assign ovf_any  = |ovf_vec;
endmodule
